// File: rtl/inta_sequencer.sv
// INTA/EOI sequencer: raises INT, walks the two-pulse 8086 INTA cycle, drives the vector byte
// and issues one-hot EOI strobes from AEOI or OCW2 commands. All outputs registered.
module inta_sequencer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inta_n,
  input  logic [7:0] highest_priority_interrupt,
  input  logic [7:0] in_service_register,
  input  logic [4:0] vector_base,
  input  logic       auto_eoi,
  input  logic       ocw2_write,
  input  logic [2:0] ocw2_eoi_mode,
  input  logic [2:0] ocw2_level,
  output logic       int_out,
  output logic       acknowledge,
  output logic [7:0] end_of_interrupt,
  output logic [7:0] data_out,
  output logic       data_oe
);

  typedef enum logic [2:0] {IDLE, PEND, ACK1, GAP, ACK2} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   inta_d_q;
  logic                   inta_s, fall, rise;
  logic                   int_out_q, int_out_d;
  logic                   ack_q, ack_d;
  logic [7:0]             eoi_q, eoi_d;
  logic [7:0]             data_out_q, data_out_d;
  logic                   data_oe_q, data_oe_d;
  logic [2:0]             level_q, level_d;
  logic                   spurious_q, spurious_d;
  logic [7:0]             aeoi_eoi, ocw_eoi;

  // Lowest set index wins when the resolver output is not one-hot.
  function automatic logic [2:0] encode_lowest(input logic [7:0] v);
    encode_lowest = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) encode_lowest = 3'(i);
    end
  endfunction

  assign inta_s = sync_q[SYNC_STAGES-1];
  assign fall   = inta_d_q & ~inta_s;
  assign rise   = ~inta_d_q & inta_s;

  always_comb begin
    state_d    = state_q;
    int_out_d  = int_out_q;
    ack_d      = 1'b0;
    data_out_d = data_out_q;
    data_oe_d  = data_oe_q;
    level_d    = level_q;
    spurious_d = spurious_q;
    aeoi_eoi   = 8'd0;
    ocw_eoi    = 8'd0;

    case (state_q)
      IDLE: begin
        if (highest_priority_interrupt != 8'd0) begin
          state_d   = PEND;
          int_out_d = 1'b1;
        end
      end
      PEND: begin
        if (fall) begin
          state_d   = ACK1;
          int_out_d = 1'b0;
          if (highest_priority_interrupt == 8'd0) begin
            level_d    = 3'd7;
            spurious_d = 1'b1;
          end else begin
            level_d    = encode_lowest(highest_priority_interrupt);
            spurious_d = 1'b0;
            ack_d      = 1'b1;
          end
        end
      end
      ACK1: begin
        data_oe_d = 1'b0;
        if (rise) state_d = GAP;
      end
      GAP: begin
        if (fall) begin
          state_d    = ACK2;
          data_oe_d  = 1'b1;
          data_out_d = {vector_base, level_q};
        end
      end
      ACK2: begin
        if (rise) begin
          state_d    = IDLE;
          data_oe_d  = 1'b0;
          data_out_d = 8'd0;
          spurious_d = 1'b0;
          if (auto_eoi && !spurious_q) aeoi_eoi = 8'h01 << level_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (ocw2_write) begin
      case (ocw2_eoi_mode)
        3'b001:  ocw_eoi = in_service_register & (~in_service_register + 8'd1);
        3'b011:  ocw_eoi = 8'h01 << ocw2_level;
        default: ocw_eoi = 8'd0;
      endcase
    end

    eoi_d = aeoi_eoi | ocw_eoi;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sync_q     <= '1;
      inta_d_q   <= 1'b1;
      int_out_q  <= 1'b0;
      ack_q      <= 1'b0;
      eoi_q      <= 8'd0;
      data_out_q <= 8'd0;
      data_oe_q  <= 1'b0;
      level_q    <= 3'd0;
      spurious_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], inta_n};
      inta_d_q   <= inta_s;
      int_out_q  <= int_out_d;
      ack_q      <= ack_d;
      eoi_q      <= eoi_d;
      data_out_q <= data_out_d;
      data_oe_q  <= data_oe_d;
      level_q    <= level_d;
      spurious_q <= spurious_d;
    end
  end

  assign int_out          = int_out_q;
  assign acknowledge      = ack_q;
  assign end_of_interrupt = eoi_q;
  assign data_out         = data_out_q;
  assign data_oe          = data_oe_q;

endmodule

// File: doc/inta_sequencer.md
Name: inta_sequencer

Overview:
- CPU-facing acknowledge/EOI sequencer of the 8259A-style controller; drives the in-service register's `acknowledge` and `end_of_interrupt` inputs.
- Raises INT toward the CPU and tracks the 8086-mode two-pulse INTA cycle.
- Places the interrupt vector byte on the data bus during the second INTA pulse.
- Generates one-hot EOI strobes from automatic EOI or from OCW2 write commands.

Parameters:
- SYNC_STAGES, 2, number of flops synchronising `inta_n`; minimum 2. Sets the pin-to-event latency.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `inta_n` in 1: CPU interrupt-acknowledge pin, active-low, asynchronous to `clk`.
- `highest_priority_interrupt` in 8: one-hot winner from the priority resolver; 0 = nothing pending.
- `in_service_register` in 8: current ISR contents; used for non-specific EOI.
- `vector_base` in 5: ICW2 T7–T3.
- `auto_eoi` in 1: ICW4 AEOI bit.
- `ocw2_write` in 1: one-cycle strobe.
- `ocw2_eoi_mode` in 3: OCW2 D7–D5.
- `ocw2_level` in 3: OCW2 L2–L0.
- `int_out` out 1: INT to the CPU.
- `acknowledge` out 1: one-cycle strobe to the ISR that latches the winner.
- `end_of_interrupt` out 8: one-cycle one-hot clear strobe to the ISR.
- `data_out` out 8: vector byte.
- `data_oe` out 1: data bus drive enable.

Behaviour:
- Reset: synchronous, active-low. All outputs 0, state IDLE, synchroniser flops 1, latched level 0, spurious flag 0. Reset in any state aborts the cycle; no strobes are emitted in the reset cycle.
- Synchroniser: `inta_s` is `inta_n` after SYNC_STAGES flops; `inta_d` is `inta_s` delayed one cycle.
  - fall = `inta_d` & ~`inta_s`.
  - rise = ~`inta_d` & `inta_s`.
  - All outputs are registered. An `inta_n` change sampled at edge k produces its registered output effect after edge k+SYNC_STAGES (2-cycle latency at default).
- States: IDLE, PEND, ACK1, GAP, ACK2.
- IDLE:
  - If `highest_priority_interrupt` != 0: go to PEND and set `int_out`=1.
  - Stray fall in IDLE is ignored.
- PEND:
  - `int_out` stays 1, even if the request vanishes.
  - On fall, go to ACK1 and:
    - set `int_out`=0;
    - latch level = binary encode of `highest_priority_interrupt` (lowest set index if not one-hot);
    - if `highest_priority_interrupt`==0: level=7, spurious=1, no `acknowledge`; otherwise `acknowledge`=1 for exactly one cycle.
- ACK1:
  - `data_oe`=0; the first pulse does not drive the bus.
  - On rise, go to GAP.
- GAP:
  - On fall, go to ACK2 and set `data_oe`=1, `data_out`={`vector_base`, level[2:0]}.
  - `data_out` holds its value while in ACK2.
- ACK2:
  - On rise: `data_oe`=0, `data_out`=0, go to IDLE.
  - If `auto_eoi`=1 and spurious=0, also pulse `end_of_interrupt`=onehot(level) for one cycle. Clear spurious.
  - A new request may re-enter PEND from the cycle after the return to IDLE.
- OCW2 decode (any state), on `ocw2_write`:
  - `ocw2_eoi_mode` 001 (non-specific): `end_of_interrupt` = lowest-index set bit of `in_service_register`; 0 if ISR is 0.
  - 011 (specific): `end_of_interrupt` = onehot(`ocw2_level`).
  - All other codes: no strobe.
  - Strobe appears in the cycle after `ocw2_write`, for one cycle.
- Simultaneous AEOI strobe and OCW2 strobe: `end_of_interrupt` = bitwise OR of both.
- Consecutive `ocw2_write` cycles produce back-to-back strobes.
- `acknowledge` and `end_of_interrupt` are never held for more than one cycle per event.

Test Plan:
- Normal cycle, default sync:
  - Reset; `highest_priority_interrupt`=0x08, `vector_base`=5'b01000, `auto_eoi`=0.
  - Expect `int_out`=1 one cycle later.
  - First `inta_n` pulse low 4 cycles: `acknowledge` is one cycle high 2 cycles after the fall; `int_out`→0; `data_oe`=0.
  - Second pulse: `data_out`=0x43, `data_oe`=1 until 2 cycles after `inta_n` rises.
- AEOI: same as above with `auto_eoi`=1. Expect `end_of_interrupt`=0x08 for one cycle, coincident with `data_oe` falling.
- Spurious:
  - Request 0x04 raises `int_out`, then drops to 0 before the first fall.
  - Expect no `acknowledge`, `data_out`={base,3'b111}.
  - With `auto_eoi`=1, expect no EOI strobe.
- OCW2:
  - `in_service_register`=0x28, mode 001 → `end_of_interrupt`=0x08.
  - Mode 011, level 5 → 0x20.
  - Mode 010 → 0x00.
  - ISR=0 with mode 001 → 0x00.
- Collision: AEOI level 2 and OCW2 specific level 6 in the same cycle → `end_of_interrupt`=0x44.
- Reset mid-cycle:
  - Assert `rst_n`=0 while in GAP; expect all outputs 0 next edge, state IDLE.
  - A subsequent stray `inta_n` pulse with no request produces no `acknowledge`/`data_oe`.
